// File: rtl/regfile_2r2w_sb.sv
// Two-read, general-write plus link-write register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_2r2w_sb #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_ADR    = 31,
    parameter int PC_INC      = 2,
    parameter int ZERO_REG_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_adr_1,
    input  logic [ADDR_W-1:0] read_adr_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              read_busy_1,
    output logic              read_busy_2,
    input  logic [ADDR_W-1:0] write_adr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              RegWrite,
    input  logic              Jal,
    input  logic [DATA_W-1:0] pc,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_adr,
    output logic [ADDR_W:0]   busy_count
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_ADR);
    localparam logic [ADDR_W-1:0] ZERO_A = '0;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   busy_count_next;
    logic [DATA_W-1:0] link_value;
    logic              link_we;
    logic              gen_we;
    logic              set_we;

    logic [ADDR_W-1:0] rd_adr  [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    function automatic logic is_zero(input logic [ADDR_W-1:0] adr);
        return (ZERO_REG_EN != 0) && (adr == ZERO_A);
    endfunction

    // Link value wraps modulo 2**DATA_W; the link write wins over a general write to the same register.
    assign link_value = pc + DATA_W'(PC_INC);
    assign link_we    = Jal && !is_zero(LINK_A);
    assign gen_we     = RegWrite && !is_zero(write_adr) && !(Jal && (write_adr == LINK_A));
    assign set_we     = busy_set && !is_zero(busy_adr);

    // Clears first, then set: a new producer issued in the retiring cycle keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (gen_we) begin
            busy_next[write_adr] = 1'b0;
        end
        if (link_we) begin
            busy_next[LINK_A] = 1'b0;
        end
        if (set_we) begin
            busy_next[busy_adr] = 1'b1;
        end
    end

    always_comb begin
        busy_count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count_next = busy_count_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (gen_we) begin
                regs[write_adr] <= write_data;
            end
            if (link_we) begin
                regs[LINK_A] <= link_value;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= busy_count_next;
        end
    end

    assign rd_adr[0] = read_adr_1;
    assign rd_adr[1] = read_adr_2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs[rd_adr[p]];
            rd_busy[p] = busy[rd_adr[p]];
`ifdef REGFILE_BYPASS_EN
            if (Jal && (rd_adr[p] == LINK_A)) begin
                rd_data[p] = link_value;
            end else if (RegWrite && (rd_adr[p] == write_adr)) begin
                rd_data[p] = write_data;
            end
            // A register retiring this cycle reads as ready unless it is re-issued in the same cycle.
            if (((link_we && (rd_adr[p] == LINK_A)) || (gen_we && (rd_adr[p] == write_adr)))
                && !(set_we && (busy_adr == rd_adr[p]))) begin
                rd_busy[p] = 1'b0;
            end
`endif
            if (is_zero(rd_adr[p])) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign read_data_1 = rd_data[0];
    assign read_data_2 = rd_data[1];
    assign read_busy_1 = rd_busy[0];
    assign read_busy_2 = rd_busy[1];

endmodule

// File: tb/tb_regfile_2r2w_sb.sv
// Directed bench for regfile_2r2w_sb: reset, read/write, link conflict, scoreboard, bypass, fill.
module tb_regfile_2r2w_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_adr_1;
    logic [4:0]  read_adr_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic        read_busy_1;
    logic        read_busy_2;
    logic [4:0]  write_adr;
    logic [31:0] write_data;
    logic        RegWrite;
    logic        Jal;
    logic [31:0] pc;
    logic        busy_set;
    logic [4:0]  busy_adr;
    logic [5:0]  busy_count;

    int checks;
    int errors;

    regfile_2r2w_sb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_adr_1  (read_adr_1),
        .read_adr_2  (read_adr_2),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .read_busy_1 (read_busy_1),
        .read_busy_2 (read_busy_2),
        .write_adr   (write_adr),
        .write_data  (write_data),
        .RegWrite    (RegWrite),
        .Jal         (Jal),
        .pc          (pc),
        .busy_set    (busy_set),
        .busy_adr    (busy_adr),
        .busy_count  (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0;
        Jal      = 1'b0;
        busy_set = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] adr, input logic [31:0] data);
        RegWrite   = 1'b1;
        write_adr  = adr;
        write_data = data;
        tick();
        idle();
    endtask

    task automatic do_busy(input logic [4:0] adr);
        busy_set = 1'b1;
        busy_adr = adr;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (read_data_1 !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h want %h", read_data_1, 32'h0);
        end
        checks++;
        if (busy_count !== 6'd0 || read_busy_1 !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %0d/%b want 0/0", busy_count, read_busy_1);
        end
        tick();
        rst_n = 1'b1;
        do_write(5'd5, 32'hDEADBEEF);
        do_busy(5'd9);
        read_adr_1 = 5'd5;
        #1;
        checks++;
        if (read_data_1 !== 32'hDEADBEEF || busy_count !== 6'd1) begin
            errors++; $display("FAIL pre_reset_r5 got %h/%0d want deadbeef/1", read_data_1, busy_count);
        end
        // Reset asserted mid-cycle together with a pending write and busy_set.
        RegWrite = 1'b1; write_adr = 5'd6; write_data = 32'h1234;
        busy_set = 1'b1; busy_adr = 5'd7;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (read_data_1 !== 32'h0 || busy_count !== 6'd0) begin
            errors++; $display("FAIL async_reset got %h/%0d want 0/0", read_data_1, busy_count);
        end
        tick();
        idle();
        rst_n = 1'b1;
        read_adr_1 = 5'd6; read_adr_2 = 5'd7;
        #1;
        checks++;
        if (read_data_1 !== 32'h0 || read_busy_2 !== 1'b0 || busy_count !== 6'd0) begin
            errors++; $display("FAIL reset_discard got %h/%b/%0d want 0/0/0", read_data_1, read_busy_2, busy_count);
        end
    endtask

    task automatic test_write_read();
        do_write(5'd7, 32'h12345678);
        read_adr_1 = 5'd7; read_adr_2 = 5'd7;
        #1;
        checks++;
        if (read_data_1 !== 32'h12345678 || read_data_2 !== 32'h12345678) begin
            errors++; $display("FAIL rw_r7 got %h/%h want 12345678", read_data_1, read_data_2);
        end
        do_write(5'd0, 32'hFFFFFFFF);
        read_adr_1 = 5'd0;
        #1;
        checks++;
        if (read_data_1 !== 32'h0) begin
            errors++; $display("FAIL rw_r0 got %h want 0", read_data_1);
        end
    endtask

    task automatic test_link();
        pc = 32'h100; Jal = 1'b1; RegWrite = 1'b1; write_adr = 5'd31; write_data = 32'hAAAA;
        tick();
        idle();
        read_adr_1 = 5'd31;
        #1;
        checks++;
        if (read_data_1 !== 32'h102) begin
            errors++; $display("FAIL link_conflict got %h want 102", read_data_1);
        end
        pc = 32'hFFFFFFFF; Jal = 1'b1; RegWrite = 1'b1; write_adr = 5'd31; write_data = 32'hAAAA;
        tick();
        idle();
        #1;
        checks++;
        if (read_data_1 !== 32'h1) begin
            errors++; $display("FAIL link_wrap got %h want 1", read_data_1);
        end
        pc = 32'h40; Jal = 1'b1; RegWrite = 1'b1; write_adr = 5'd4; write_data = 32'hBEEF;
        tick();
        idle();
        read_adr_2 = 5'd4;
        #1;
        checks++;
        if (read_data_1 !== 32'h42 || read_data_2 !== 32'hBEEF) begin
            errors++; $display("FAIL link_dual got %h/%h want 42/beef", read_data_1, read_data_2);
        end
    endtask

    task automatic test_scoreboard();
        do_busy(5'd9);
        read_adr_1 = 5'd9;
        #1;
        checks++;
        if (read_busy_1 !== 1'b1 || busy_count !== 6'd1) begin
            errors++; $display("FAIL sb_set got %b/%0d want 1/1", read_busy_1, busy_count);
        end
        do_write(5'd9, 32'h99);
        checks++;
        if (read_busy_1 !== 1'b0 || busy_count !== 6'd0) begin
            errors++; $display("FAIL sb_clear got %b/%0d want 0/0", read_busy_1, busy_count);
        end
        RegWrite = 1'b1; write_adr = 5'd9; write_data = 32'h98;
        busy_set = 1'b1; busy_adr = 5'd9;
        tick();
        idle();
        checks++;
        if (read_busy_1 !== 1'b1 || busy_count !== 6'd1) begin
            errors++; $display("FAIL sb_set_wins got %b/%0d want 1/1", read_busy_1, busy_count);
        end
        do_busy(5'd9);
        checks++;
        if (busy_count !== 6'd1) begin
            errors++; $display("FAIL sb_reset_busy got %0d want 1", busy_count);
        end
        do_busy(5'd0);
        read_adr_2 = 5'd0;
        #1;
        checks++;
        if (busy_count !== 6'd1 || read_busy_2 !== 1'b0) begin
            errors++; $display("FAIL sb_zero got %0d/%b want 1/0", busy_count, read_busy_2);
        end
        do_busy(5'd31);
        checks++;
        if (busy_count !== 6'd2) begin
            errors++; $display("FAIL sb_two got %0d want 2", busy_count);
        end
        pc = 32'h0; Jal = 1'b1;
        tick();
        idle();
        read_adr_2 = 5'd31;
        #1;
        checks++;
        if (busy_count !== 6'd1 || read_busy_2 !== 1'b0 || read_busy_1 !== 1'b1) begin
            errors++; $display("FAIL sb_link_clear got %0d/%b/%b want 1/0/1", busy_count, read_busy_2, read_busy_1);
        end
        do_write(5'd9, 32'h0);
        checks++;
        if (busy_count !== 6'd0) begin
            errors++; $display("FAIL sb_empty got %0d want 0", busy_count);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_data;
        logic        exp_busy;
`ifdef REGFILE_BYPASS_EN
        exp_data = 32'h55;
        exp_busy = 1'b0;
`else
        exp_data = 32'h11;
        exp_busy = 1'b1;
`endif
        do_write(5'd3, 32'h11);
        do_busy(5'd3);
        read_adr_1 = 5'd3;
        RegWrite = 1'b1; write_adr = 5'd3; write_data = 32'h55;
        #1;
        checks++;
        if (read_data_1 !== exp_data || read_busy_1 !== exp_busy) begin
            errors++; $display("FAIL bypass_same_cycle got %h/%b want %h/%b", read_data_1, read_busy_1, exp_data, exp_busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (read_data_1 !== 32'h55 || read_busy_1 !== 1'b0 || busy_count !== 6'd0) begin
            errors++; $display("FAIL bypass_after got %h/%b/%0d want 55/0/0", read_data_1, read_busy_1, busy_count);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i < 32; i++) begin
            do_busy(5'(i));
        end
        checks++;
        if (busy_count !== 6'd31) begin
            errors++; $display("FAIL fill_count got %0d want 31", busy_count);
        end
        pc = 32'h200; Jal = 1'b1;
        RegWrite = 1'b1; write_adr = 5'd2; write_data = 32'h77;
        tick();
        idle();
        checks++;
        if (busy_count !== 6'd29) begin
            errors++; $display("FAIL fill_dual_clear got %0d want 29", busy_count);
        end
        read_adr_1 = 5'd2; read_adr_2 = 5'd31;
        #1;
        checks++;
        if (read_data_1 !== 32'h77 || read_data_2 !== 32'h202 || read_busy_1 !== 1'b0 || read_busy_2 !== 1'b0) begin
            errors++; $display("FAIL fill_values got %h/%h/%b/%b want 77/202/0/0", read_data_1, read_data_2, read_busy_1, read_busy_2);
        end
        read_adr_1 = 5'd1;
        #1;
        checks++;
        if (read_busy_1 !== 1'b1) begin
            errors++; $display("FAIL fill_r1_busy got %b want 1", read_busy_1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        read_adr_1 = '0; read_adr_2 = '0;
        write_adr = '0; write_data = '0;
        pc = '0; busy_adr = '0;
        idle();
        #1;
        test_reset();
        test_write_read();
        test_link();
        test_scoreboard();
        test_bypass();
        test_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
